// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter (and its paired receiver):
//   tx_state_t    - transmitter FSM states
//   UART_IDLE     - line level while idle and during stop bits (mark)
//   UART_START    - line level of the start bit (space)
//   frame_clocks  - clocks occupied by one frame on the line, for benches
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    // Start bit + data bits + optional parity bit + stop bits, each DIVISOR clocks.
    function automatic int frame_clocks(input int width, input int divisor,
                                        input int stop_bits, input bit parity);
        return (1 + width + stop_bits + int'(parity)) * divisor;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running divide-by-DIVISOR counter. o_tick is high for the one clock in
// which the count equals DIVISOR-1, i.e. the last clock of each bit period.
// Ports:
//   clk      - system clock
//   i_reset  - synchronous, active-high reset (count = 0)
//   i_clear  - synchronous clear; the next count is 0 (restarts a bit period)
//   o_tick   - last clock of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIVISOR = 4
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clear || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART serializer: accepts a word over valid/ready and sends
//   start (0), WIDTH data bits MSB-first, [even parity], STOP_BITS stop (1)
// with every bit held DIVISOR clocks on a registered, idle-high line.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
// Ports:
//   clk          - system clock, all logic on posedge
//   i_reset      - synchronous, active-high reset; aborts any frame
//   i_data       - word to send, sampled only on accept
//   i_data_valid - source has a word
//   o_ready      - can accept (high only in IDLE)
//   o_tx         - serial line
//   o_busy       - frame in progress (= ~o_ready)
//   o_done       - one-clock pulse in the last clock of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIVISOR   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_data_valid,
    output logic             o_ready,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;   // data bits, then reused for stop bits
    logic             tx_q, tx_d;
    logic             tick;
    logic             accept;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign accept  = i_data_valid && (state_q == IDLE);
    assign o_ready = (state_q == IDLE);
    assign o_busy  = ~o_ready;
    assign o_tx    = tx_q;
    assign o_done  = (state_q == STOP) && tick && (bit_cnt_q == LAST_STOP);

    // Restarting the bit period on every state change keeps each bit exactly
    // DIVISOR clocks regardless of where the counter was when the word arrived.
    uart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud_gen (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clear (state_d != state_q),
        .o_tick  (tick)
    );

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = i_data;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^i_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q << 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered from the next state, so o_tx changes on the
        // same edge as the state and stays aligned with o_ready/o_done.
        tx_d = UART_IDLE;
        case (state_d)
            START:   tx_d = UART_START;
            DATA:    tx_d = shift_d[WIDTH-1];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = UART_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx. Two instances: u_dut (WIDTH=8, DIVISOR=4, STOP_BITS=1)
// and u_dut1 (WIDTH=8, DIVISOR=1, STOP_BITS=2). Expected line levels come from
// a frame-level reference: bit index = clock / DIVISOR, mapped to start, data
// MSB-first, optional parity, stop. A behavioural receiver decodes the line
// for the loopback scenario.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int DIV = 4;
    localparam int FL  = uart_pkg::frame_clocks(8, DIV, 1, PAR);
    localparam int FL1 = uart_pkg::frame_clocks(8, 1, 2, PAR);
    localparam int NS  = 256;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_data = '0;
    logic       i_data_valid = 1'b0;
    logic       o_ready, o_tx, o_busy, o_done;
    logic [7:0] i_data1 = '0;
    logic       i_data_valid1 = 1'b0;
    logic       o_ready1, o_tx1, o_busy1, o_done1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(8), .DIVISOR(DIV), .STOP_BITS(1)) u_dut (
        .clk (clk), .i_reset (i_reset), .i_data (i_data), .i_data_valid (i_data_valid),
        .o_ready (o_ready), .o_tx (o_tx), .o_busy (o_busy), .o_done (o_done)
    );

    uart_tx #(.WIDTH(8), .DIVISOR(1), .STOP_BITS(2)) u_dut1 (
        .clk (clk), .i_reset (i_reset), .i_data (i_data1), .i_data_valid (i_data_valid1),
        .o_ready (o_ready1), .o_tx (o_tx1), .o_busy (o_busy1), .o_done (o_done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level k clocks after the accept edge.
    function automatic logic exp_bit(input logic [7:0] w, input int k, input int div,
                                     input int stop_bits);
        int idx;
        idx = k / div;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[8 - idx];
        if (PAR && idx == 9) return ^w;
        if (idx < 9 + int'(PAR) + stop_bits) return 1'b1;
        return 1'b1;
    endfunction

    // Sends w on u_dut and checks every clock of the frame. glitch_k pulses
    // valid with 0xFF at that clock; reset_k asserts reset at that clock.
    task automatic frame_run(input logic [7:0] w, input int glitch_k, input int reset_k,
                             input string name);
        int lim;
        i_data = w;
        i_data_valid = 1'b1;
        lim = 0;
        while (o_ready !== 1'b1 && lim < 200) begin
            step();
            lim++;
        end
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL %s ready_wait got %b want 1", name, o_ready);
        else pass_cnt++;
        step();                       // accept edge
        i_data_valid = 1'b0;
        i_data = ~w;                  // must not disturb the frame
        for (int k = 0; k < FL; k++) begin
            total_cnt++;
            if (o_tx !== exp_bit(w, k, DIV, 1))
                $display("FAIL %s tx k=%0d got %b want %b", name, k, o_tx, exp_bit(w, k, DIV, 1));
            else pass_cnt++;
            total_cnt++;
            if (o_done !== (k == FL - 1))
                $display("FAIL %s done k=%0d got %b want %b", name, k, o_done, (k == FL - 1));
            else pass_cnt++;
            total_cnt++;
            if (o_busy !== 1'b1 || o_ready !== 1'b0)
                $display("FAIL %s busy k=%0d got busy=%b ready=%b want 1/0", name, k, o_busy, o_ready);
            else pass_cnt++;
            if (k == glitch_k) begin
                i_data = 8'hFF;
                i_data_valid = 1'b1;
            end
            if (k == glitch_k + 1) i_data_valid = 1'b0;
            if (k == reset_k) begin
                i_reset = 1'b1;
                step();
                total_cnt++;
                if (o_tx !== 1'b1 || o_done !== 1'b0)
                    $display("FAIL %s reset_abort got tx=%b done=%b want 1/0", name, o_tx, o_done);
                else pass_cnt++;
                i_reset = 1'b0;
                step();
                total_cnt++;
                if (o_ready !== 1'b1 || o_tx !== 1'b1)
                    $display("FAIL %s after_reset got ready=%b tx=%b want 1/1", name, o_ready, o_tx);
                else pass_cnt++;
                return;
            end
            step();
        end
        total_cnt++;
        if (o_ready !== 1'b1 || o_tx !== 1'b1 || o_done !== 1'b0)
            $display("FAIL %s frame_end got ready=%b tx=%b done=%b want 1/1/0", name, o_ready, o_tx, o_done);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_ready !== 1'b1 || o_tx !== 1'b1)
            $display("FAIL %s no_queued got ready=%b tx=%b want 1/1", name, o_ready, o_tx);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_data = 8'hAA;
        i_data_valid = 1'b1;
        i_data1 = 8'h55;
        i_data_valid1 = 1'b1;
        step();
        step();
        total_cnt++;
        if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0)
            $display("FAIL reset_state got tx=%b ready=%b busy=%b done=%b want 1/1/0/0",
                     o_tx, o_ready, o_busy, o_done);
        else pass_cnt++;
        total_cnt++;
        if (o_tx1 !== 1'b1 || o_ready1 !== 1'b1 || o_busy1 !== 1'b0 || o_done1 !== 1'b0)
            $display("FAIL reset_state1 got tx=%b ready=%b busy=%b done=%b want 1/1/0/0",
                     o_tx1, o_ready1, o_busy1, o_done1);
        else pass_cnt++;
        i_reset = 1'b0;
        i_data_valid = 1'b0;
        i_data_valid1 = 1'b0;
        step();
        total_cnt++;
        if (o_tx !== 1'b1 || o_ready !== 1'b1)
            $display("FAIL reset_wins got tx=%b ready=%b want 1/1", o_tx, o_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        frame_run(8'hA5, -10, -1, "single_a5");
        frame_run(8'($urandom), -10, -1, "single_rand");
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[4];
        logic       samp[NS];
        int         acc[$];
        logic [7:0] rx_q[$];
        int         idx;
        logic       pending;
        logic [7:0] w;
        int         k;
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        idx = 0;
        i_data = words[0];
        i_data_valid = 1'b1;
        for (int cyc = 0; cyc < NS; cyc++) begin
            samp[cyc] = o_tx;
            pending = o_ready && i_data_valid;
            if (pending) acc.push_back(cyc + 1);
            step();
            if (pending) begin
                idx++;
                if (idx < 4) i_data = words[idx];
                else i_data_valid = 1'b0;
            end
        end
        // Behavioural receiver: falling edge marks a start bit, sample mid-bit.
        k = 1;
        while (k + FL < NS) begin
            if (samp[k - 1] == 1'b1 && samp[k] == 1'b0 && samp[k + DIV / 2] == 1'b0) begin
                for (int b = 0; b < 8; b++) w[7 - b] = samp[k + (1 + b) * DIV + DIV / 2];
                rx_q.push_back(w);
                k += FL;
            end else begin
                k++;
            end
        end
        total_cnt++;
        if (rx_q.size() != 4 || acc.size() != 4)
            $display("FAIL loop_count got rx=%0d acc=%0d want 4/4", rx_q.size(), acc.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            total_cnt++;
            if (rx_q[i] !== words[i])
                $display("FAIL loop_word%0d got %h want %h", i, rx_q[i], words[i]);
            else pass_cnt++;
        end
        for (int i = 0; i + 1 < acc.size(); i++) begin
            total_cnt++;
            if (acc[i + 1] - acc[i] != FL + 1)
                $display("FAIL loop_spacing%0d got %0d want %0d", i, acc[i + 1] - acc[i], FL + 1);
            else pass_cnt++;
        end
        if (acc.size() > 0) begin
            total_cnt++;
            if (samp[acc[0]] !== 1'b0)
                $display("FAIL loop_latency got %b want 0", samp[acc[0]]);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore();
        frame_run(8'h3C, 10, -1, "busy_ignore");
    endtask

    task automatic test_reset_mid_frame();
        // Data bit 3 (MSB-first) of 0x81 is line bit 4.
        frame_run(8'h81, -10, 4 * DIV + 1, "reset_mid");
        frame_run(8'h42, -10, -1, "after_reset_42");
    endtask

    task automatic test_div1();
        i_data1 = 8'h01;
        i_data_valid1 = 1'b1;
        step();
        i_data_valid1 = 1'b0;
        i_data1 = 8'hFE;
        for (int k = 0; k < FL1; k++) begin
            total_cnt++;
            if (o_tx1 !== exp_bit(8'h01, k, 1, 2) || o_done1 !== (k == FL1 - 1))
                $display("FAIL div1 k=%0d got tx=%b done=%b want %b/%b", k, o_tx1, o_done1,
                         exp_bit(8'h01, k, 1, 2), (k == FL1 - 1));
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (o_ready1 !== 1'b1 || o_tx1 !== 1'b1)
            $display("FAIL div1_end got ready=%b tx=%b want 1/1", o_ready1, o_tx1);
        else pass_cnt++;
    endtask

    task automatic test_parity();
        frame_run(8'hA5, -10, -1, "parity_a5");
        frame_run(8'h07, -10, -1, "parity_07");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_div1();
        test_parity();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
